// File: rtl/arb_pkg.sv
// arb_pkg: shared definitions for the round-robin arbiter.
//   - arb_state_e : FSM state encoding (ST_IDLE, ST_GRANT)
//   - DEF_NREQ / DEF_MAX_HOLD : default parameter values
//   - arb_clog2 / arb_cnt_w   : width helpers
package arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

  // Ceiling log2; arb_clog2(1) == 0.
  function automatic int unsigned arb_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

  // Hold counter width: a MAX_HOLD of 1 still needs a 1-bit counter.
  function automatic int unsigned arb_cnt_w(input int unsigned max_hold);
    return (arb_clog2(max_hold) == 0) ? 1 : arb_clog2(max_hold);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority search.
//   Finds the first set bit of req_i, searching upward from start_i and
//   wrapping NREQ-1 -> 0.
//   req_i   : request vector
//   start_i : index to start searching from (must be < NREQ)
//   idx_o   : index of the found requester (0 when none)
//   vld_o   : a requester was found
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  logic [IW-1:0] cur;

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cur   = start_i;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!vld_o && req_i[cur]) begin
        idx_o = cur;
        vld_o = 1'b1;
      end
      // Explicit wrap: NREQ need not be a power of two.
      cur = (cur == IW'(NREQ - 1)) ? '0 : cur + IW'(1);
    end
  end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// rr_arbiter_fsm: Moore round-robin arbiter with bounded hold time.
//   Clock  : rising-edge clock
//   Resetn : synchronous active-low reset
//   req    : request vector, bit i = requester i
//   grant  : registered one-hot (or zero) grant
//   gnt_id : index of the granted requester, 0 when idle
//   busy   : registered, equals |grant
// Optional feature macro: ARB_IDLE_GAP_EN -- every release passes through
// one IDLE cycle (grant=0) before the next arbitration from the updated ptr.
module rr_arbiter_fsm
  import arb_pkg::*;
#(
  parameter  int unsigned NREQ     = DEF_NREQ,
  parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned IW       = arb_clog2(NREQ),
  localparam int unsigned CW       = arb_cnt_w(MAX_HOLD)
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gnt_id,
  output logic            busy
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  arb_state_e      st_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   gnt_id_q;   // doubles as k while in ST_GRANT
  logic            busy_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;

  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   cnt_d;
  logic            release_w;
  logic [IW-1:0]   idle_idx;
  logic            idle_vld;

  // Next rotation start after k, wrapped explicitly.
  assign ptr_d     = (gnt_id_q == IW'(NREQ - 1)) ? '0 : gnt_id_q + IW'(1);
  assign cnt_d     = cnt_q + CW'(1);
  assign release_w = !req[gnt_id_q] || (cnt_q == CW'(MAX_HOLD - 1));

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_idle (
    .req_i   (req),
    .start_i (ptr_q),
    .idx_o   (idle_idx),
    .vld_o   (idle_vld)
  );

`ifdef ARB_IDLE_GAP_EN
  // Release always lands in IDLE; the idle picker arbitrates next cycle.
`else
  logic [IW-1:0] rel_idx;
  logic          rel_vld;

  // Searches from k+1, so k itself is considered last (sole-requester regrant).
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_rel (
    .req_i   (req),
    .start_i (ptr_d),
    .idx_o   (rel_idx),
    .vld_o   (rel_vld)
  );
`endif

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      st_q     <= ST_IDLE;
      grant_q  <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (idle_vld) begin
            st_q     <= ST_GRANT;
            grant_q  <= ONE << idle_idx;
            gnt_id_q <= idle_idx;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        ST_GRANT: begin
          if (release_w) begin
            ptr_q <= ptr_d;
            cnt_q <= '0;
`ifdef ARB_IDLE_GAP_EN
            st_q     <= ST_IDLE;
            grant_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
`else
            if (rel_vld) begin
              grant_q  <= ONE << rel_idx;
              gnt_id_q <= rel_idx;
            end else begin
              st_q     <= ST_IDLE;
              grant_q  <= '0;
              gnt_id_q <= '0;
              busy_q   <= 1'b0;
            end
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

  assign grant  = grant_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule
